// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes and the remainder sequencer state encoding.
package alu_pkg;
   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_MOD = 4'b1011;
   typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} mod_state_e;
endpackage

// File: rtl/mod_sequencer.sv
// mod_sequencer: REM/REMU via a restoring shift-subtract loop on the shared ALU's SUB.
module mod_sequencer
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [XLEN-1:0] req_dividend,
   input  logic [XLEN-1:0] req_divisor,
   input  logic            req_signed,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rem,
   output logic            busy,
   output logic            alu_req,
   output logic [XLEN-1:0] alu_opr_a,
   output logic [XLEN-1:0] alu_opr_b,
   output logic [3:0]      alu_op,
   input  logic [XLEN-1:0] alu_res
);
   localparam int CW = $clog2(XLEN);
   mod_state_e      state;
   logic [XLEN-1:0] dvd, dsr, rem;
   logic [CW-1:0]   cnt;
   logic            sgn, neg;
   logic [XLEN:0]   shifted;
   logic            ge;
   assign shifted   = {rem, dvd[XLEN-1]};
   assign ge        = shifted[XLEN] | (shifted[XLEN-1:0] >= dsr);
   assign req_ready = state == S_IDLE;
   assign busy      = state != S_IDLE;
   assign rsp_valid = state == S_DONE;
   assign alu_req   = state == S_ITER || state == S_FIX;
   // FIX reuses the ALU to apply the dividend's sign: 0 - rem or rem + 0
   assign alu_op    = (state == S_ITER || (state == S_FIX && neg)) ? ALU_SUB : ALU_ADD;
   assign alu_opr_a = state == S_ITER ? shifted[XLEN-1:0] : (state == S_FIX && !neg) ? rem : '0;
   assign alu_opr_b = state == S_ITER ? dsr : (state == S_FIX && neg) ? rem : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         dvd     <= '0;
         dsr     <= '0;
         rem     <= '0;
         cnt     <= '0;
         sgn     <= 1'b0;
         neg     <= 1'b0;
         rsp_rem <= '0;
      end else if (flush) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (req_valid) begin
               dvd   <= req_dividend;
               dsr   <= req_divisor;
               sgn   <= req_signed;
               state <= S_PREP;
            end
            S_PREP: begin
               neg <= sgn & dvd[XLEN-1];
               dvd <= (sgn && dvd[XLEN-1]) ? '0 - dvd : dvd;
               dsr <= (sgn && dsr[XLEN-1]) ? '0 - dsr : dsr;
               rem <= '0;
               cnt <= CW'(XLEN - 1);
               // x % 0 returns the untouched dividend
               if (dsr == '0) begin
                  rsp_rem <= dvd;
                  state   <= S_DONE;
               end else begin
                  state <= S_ITER;
               end
            end
            S_ITER: begin
               dvd <= dvd << 1;
               rem <= ge ? alu_res : shifted[XLEN-1:0];
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= S_FIX;
            end
            S_FIX: begin
               rsp_rem <= alu_res;
               state   <= S_DONE;
            end
            S_DONE: if (rsp_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/mod_sequencer.md
# mod_sequencer

Multi-cycle sequencer that computes RISC-V REM/REMU remainders by driving the shared ALU's SUB operation through a 32-step restoring shift-subtract loop. It implements the reserved MOD aluop (4'b1011), which the combinational ALU does not execute. It sits beside the ALU in the execute stage. The execute stage hands it a request, stalls on `busy`, and muxes the ALU operand/opcode inputs to this block while `alu_req` is high.

## Interface
- `XLEN`, default 32: operand width. Iteration count equals `XLEN`.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous abort. Drops any operation in progress without a response.
- `req_valid`  in  1: request offered.
- `req_ready`  out  1: high only in IDLE.
- `req_dividend`  in  XLEN: dividend, sampled at accept.
- `req_divisor`  in  XLEN: divisor, sampled at accept.
- `req_signed`  in  1: 1 = REM (signed), 0 = REMU (unsigned).
- `rsp_valid`  out  1: remainder available.
- `rsp_ready`  in  1: consumer accepts remainder.
- `rsp_rem`  out  XLEN: remainder, stable while `rsp_valid` is high.
- `busy`  out  1: high in every state except IDLE.
- `alu_req`  out  1: sequencer owns the ALU this cycle (ITER, FIX).
- `alu_opr_a`, `alu_opr_b`  out  XLEN: ALU operands. Zero when `alu_req` is low.
- `alu_op`  out  4: ALU opcode. `ALU_ADD` when `alu_req` is low.
- `alu_res`  in  XLEN: combinational ALU result, same cycle.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE: accept when `req_valid && req_ready`. Latch operands and `req_signed`. Go to PREP.
- PREP (1 cycle):
  - If signed, replace dividend and divisor with their magnitudes (local two's-complement negate). Record `neg = signed && dividend[XLEN-1]`.
  - Clear `rem`. Load `cnt = XLEN-1`.
  - If divisor == 0: set result = original dividend and go to DONE (RISC-V rule).
  - Otherwise go to ITER.
- ITER (XLEN cycles):
  - `shifted = {rem, dvd[XLEN-1]}` (XLEN+1 bits). Shift `dvd` left by 1.
  - Drive `alu_op=ALU_SUB`, `alu_opr_a=shifted[XLEN-1:0]`, `alu_opr_b=divisor`.
  - `ge = shifted[XLEN] | (shifted[XLEN-1:0] >= divisor)`.
  - `rem <= ge ? alu_res : shifted[XLEN-1:0]`.
  - Decrement `cnt`. Leave for FIX after the step with `cnt == 0`.
- FIX (1 cycle):
  - If `neg`: drive `ALU_SUB` with a=0, b=`rem`.
  - Else: drive `ALU_ADD` with a=`rem`, b=0.
  - Latch `alu_res` into `rsp_rem`. Go to DONE.
- DONE: `rsp_valid=1`. On `rsp_ready`, return to IDLE. Hold indefinitely under backpressure.
- Sign rule: the remainder takes the dividend's sign. The overflow case INT_MIN % -1 yields 0 naturally, since |INT_MIN| = 2^(XLEN-1) unsigned.
- `flush` in any state returns to IDLE on the next edge, with `rsp_valid` and `alu_req` low. `flush` has priority over acceptance and over `rsp_ready`.

## Timing
- Reset values: state IDLE; `req_ready=1`; `rsp_valid=0`; `rsp_rem=0`; `busy=0`; `alu_req=0`; `alu_opr_a=alu_opr_b=0`; `alu_op=ALU_ADD`. All internal registers are 0.
- Latency from accept edge to `rsp_valid` high: 1 (PREP) + XLEN (ITER) + 1 (FIX) = 34 cycles for XLEN=32.
- Divide-by-zero latency: 1 cycle (PREP to DONE).
- `req_ready` and `rsp_valid` are never high together. No new request is accepted in the cycle the response handshakes; the next accept is possible one cycle later from IDLE.
- `alu_req` is high for exactly XLEN+1 consecutive cycles per non-zero-divisor operation, and never in IDLE, PREP or DONE.
- All outputs are registered or decoded from state only. No combinational path from `req_*` or `rsp_ready` to any output.
- Asynchronous reset mid-operation: outputs return to their reset values immediately. No response is produced.

## Structure
- Shared package `alu_pkg` holds:
  - aluop constants: `ALU_ADD=4'b0000`, `ALU_SUB=4'b0001`, `ALU_MOD=4'b1011` (the opcode that triggers this block).
  - The state enum `mod_state_e`.
- The ALU itself holds these opcodes as literals today. Moving them into `alu_pkg` is part of this work.
- No sub-module. The one-step shift/compare logic stays inline. The ALU is external, and sharing it is the point of the block.

## Test plan
- REMU: dividend 17, divisor 5 -> `rsp_rem=2`. `rsp_valid` asserts 34 cycles after accept. `alu_req` is high for 33 cycles.
- REM: dividend 0xFFFFFFEF (-17), divisor 5 -> `rsp_rem=0xFFFFFFFE` (-2). Dividend 17, divisor 0xFFFFFFFB (-5) -> 2.
- Divide by zero: dividend 7, divisor 0, either mode -> `rsp_rem=7` one cycle after accept. `alu_req` never asserts.
- Overflow: REM with 0x80000000 % 0xFFFFFFFF -> 0. REMU with 0xFFFFFFFF % 0x80000000 -> 0x7FFFFFFF.
- Backpressure, then back-to-back: hold `rsp_ready=0` for 10 cycles -> `rsp_valid` and `rsp_rem` stay stable. Release -> IDLE. A second queued request is accepted the following cycle.
- Flush and reset: assert `flush` at ITER step 10 -> IDLE next cycle, no response, and a new request completes correctly. Assert `rst_n=0` mid-ITER -> all outputs immediately at reset values.
